// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back queue.
package regfile_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned WBQ_DEPTH = 4;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } wbq_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Retire-side handshake, register-file write port and bypass lookup bundle.
interface regfile_writeback_queue_if
  import regfile_pkg::*;
#(
  parameter int unsigned Depth = WBQ_DEPTH
) ();

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [XLEN-1:0]   in_data;

  logic              wr_stall;
  logic              RegWrite;
  logic [ADDR_W-1:0] rd;
  logic [XLEN-1:0]   WriteData;

  logic [ADDR_W-1:0] lk_rs1;
  logic              lk_hit1;
  logic [XLEN-1:0]   lk_data1;
  logic [ADDR_W-1:0] lk_rs2;
  logic              lk_hit2;
  logic [XLEN-1:0]   lk_data2;

  logic [CntW-1:0]   count;

  modport master (
    output in_valid, in_rd, in_data, wr_stall, lk_rs1, lk_rs2,
    input  in_ready, RegWrite, rd, WriteData, lk_hit1, lk_data1, lk_hit2, lk_data2, count
  );

  modport slave (
    input  in_valid, in_rd, in_data, wr_stall, lk_rs1, lk_rs2,
    output in_ready, RegWrite, rd, WriteData, lk_hit1, lk_data1, lk_hit2, lk_data2, count
  );

endinterface

// File: rtl/wbq_match.sv
// Youngest-first match of one register index against the queued entries.
module wbq_match
  import regfile_pkg::*;
#(
  parameter int unsigned Depth = WBQ_DEPTH,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  wbq_entry_t        entries_i [Depth],
  input  logic [PtrW-1:0]   head_i,
  input  logic [ADDR_W-1:0] rs_i,
  output logic              hit_o,
  output logic [XLEN-1:0]   data_o
);

  logic [PtrW-1:0] idx;

  // Valid entries are contiguous from the head, so walking from the head and letting
  // later matches overwrite earlier ones leaves the youngest match.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = head_i;
    for (int k = 0; k < int'(Depth); k++) begin
      idx = head_i + PtrW'(k);
      if ((rs_i != REG_ZERO) && entries_i[idx].valid && (entries_i[idx].rd == rs_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-back FIFO in front of the register file write port, with two bypass lookup ports.
module regfile_writeback_queue
  import regfile_pkg::*;
#(
  parameter int unsigned Depth = WBQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  regfile_writeback_queue_if.slave   bus
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  wbq_entry_t      entries_q [Depth];
  wbq_entry_t      entries_d [Depth];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic accept;
  logic push;
  logic pop;

  always_comb begin
    // Ready is gated by reset so nothing is accepted while reset is held.
    bus.in_ready  = reset && (count_q < DepthCnt);
    accept        = bus.in_valid && bus.in_ready;
    // Writes to x0 complete the handshake but are never stored.
    push          = accept && (bus.in_rd != REG_ZERO);
    pop           = (count_q != '0) && !bus.wr_stall;

    bus.RegWrite  = pop;
    bus.rd        = (count_q != '0) ? entries_q[head_q].rd : '0;
    bus.WriteData = (count_q != '0) ? entries_q[head_q].data : '0;
    bus.count     = count_q;
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (pop) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + PtrW'(1);
    end
    if (push) begin
      entries_d[tail_q] = '{valid: 1'b1, rd: bus.in_rd, data: bus.in_data};
      tail_d            = tail_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int k = 0; k < int'(Depth); k++) begin
        entries_q[k] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  wbq_match #(
    .Depth (Depth)
  ) u_match1 (
    .entries_i (entries_q),
    .head_i    (head_q),
    .rs_i      (bus.lk_rs1),
    .hit_o     (bus.lk_hit1),
    .data_o    (bus.lk_data1)
  );

  wbq_match #(
    .Depth (Depth)
  ) u_match2 (
    .entries_i (entries_q),
    .head_i    (head_q),
    .rs_i      (bus.lk_rs2),
    .hit_o     (bus.lk_hit2),
    .data_o    (bus.lk_data2)
  );

endmodule
